// File: rtl/code_driver.sv
// Stimulus source for the Slt/En event counter: turns count requests into the En/Slt cycle stream.
// Optional macro CODE_DRIVER_PHASE_EN exposes the mirrored Slt phase on port Phase.
module code_driver #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             ReqValid,
    output logic             ReqReady,
    input  logic [WIDTH-1:0] ReqCnt0,
    input  logic [WIDTH-1:0] ReqCnt1,
    input  logic             ReqMode,
    input  logic             Stall,
    output logic             En,
    output logic             Slt,
    output logic             Busy,
`ifdef CODE_DRIVER_PHASE_EN
    output logic [1:0]       Phase,
`endif
    output logic             Done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN0 = 2'd1,
        S_RUN1 = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ONE0 = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH+1:0] ONE1 = {{(WIDTH+1){1'b0}}, 1'b1};

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_rem0, w_rem0_nxt;
    logic [WIDTH+1:0] r_rem1, w_rem1_nxt, w_req_rem1;
    logic [1:0]       r_ph, w_ph_nxt;

    // Slt pulse count for a new request; mode 0 subtracts pulses already issued so ph lands on 0
    always_comb begin
        w_req_rem1 = {(WIDTH+2){1'b0}};
        if (ReqMode) begin
            w_req_rem1 = {2'b00, ReqCnt1};
        end else if (ReqCnt1 == {WIDTH{1'b0}}) begin
            w_req_rem1 = {(WIDTH+2){1'b0}};
        end else begin
            w_req_rem1 = {ReqCnt1, 2'b00} - {{WIDTH{1'b0}}, r_ph};
        end
    end

    // Next-state and counter update logic
    always_comb begin
        w_state_nxt = r_state;
        w_rem0_nxt  = r_rem0;
        w_rem1_nxt  = r_rem1;
        w_ph_nxt    = r_ph;
        case (r_state)
            S_IDLE: begin
                if (ReqValid) begin
                    w_rem0_nxt = ReqCnt0;
                    w_rem1_nxt = w_req_rem1;
                    if (ReqCnt0 != {WIDTH{1'b0}}) begin
                        w_state_nxt = S_RUN0;
                    end else if (w_req_rem1 != {(WIDTH+2){1'b0}}) begin
                        w_state_nxt = S_RUN1;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN0: begin
                if (!Stall) begin
                    w_rem0_nxt = r_rem0 - ONE0;
                    if (r_rem0 == ONE0) begin
                        w_state_nxt = (r_rem1 != {(WIDTH+2){1'b0}}) ? S_RUN1 : S_DONE;
                    end else begin
                        w_state_nxt = S_RUN0;
                    end
                end else begin
                    w_state_nxt = S_RUN0;
                end
            end
            S_RUN1: begin
                if (!Stall) begin
                    w_rem1_nxt = r_rem1 - ONE1;
                    w_ph_nxt   = r_ph + 2'd1;
                    w_state_nxt = (r_rem1 == ONE1) ? S_DONE : S_RUN1;
                end else begin
                    w_state_nxt = S_RUN1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs decode from state and Stall; Reset forces the idle view in the same cycle
    always_comb begin
        ReqReady = 1'b0;
        En       = 1'b0;
        Slt      = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;
        if (Reset) begin
            ReqReady = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: ReqReady = 1'b1;
                S_RUN0: begin
                    En   = !Stall;
                    Busy = 1'b1;
                end
                S_RUN1: begin
                    En   = !Stall;
                    Slt  = 1'b1;
                    Busy = 1'b1;
                end
                S_DONE: begin
                    Done = 1'b1;
                    Busy = 1'b1;
                end
                default: ReqReady = 1'b0;
            endcase
        end
    end

    // State, remaining counts and mirrored phase registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_rem0  <= {WIDTH{1'b0}};
            r_rem1  <= {(WIDTH+2){1'b0}};
            r_ph    <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_rem0  <= w_rem0_nxt;
            r_rem1  <= w_rem1_nxt;
            r_ph    <= w_ph_nxt;
        end
    end

`ifdef CODE_DRIVER_PHASE_EN
    assign Phase = r_ph;
`endif

endmodule

// File: tb/tb_code_driver.sv
// Directed self-checking bench for code_driver with a behavioural model of the downstream counter.
module tb_code_driver;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        ReqValid = 1'b0;
    logic        ReqReady;
    logic [15:0] ReqCnt0 = 16'd0;
    logic [15:0] ReqCnt1 = 16'd0;
    logic        ReqMode = 1'b0;
    logic        Stall = 1'b0;
    logic        En, Slt, Busy, Done;
`ifdef CODE_DRIVER_PHASE_EN
    logic [1:0]  Phase;
`endif

    int checks = 0;
    int errors = 0;

    // Downstream counter model: Output1 advances when the 2-bit Slt phase wraps
    int       o0 = 0;
    int       o1 = 0;
    logic [1:0] cph = 2'd0;

    code_driver #(.WIDTH(16)) dut (
        .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqCnt0(ReqCnt0), .ReqCnt1(ReqCnt1), .ReqMode(ReqMode), .Stall(Stall),
        .En(En), .Slt(Slt), .Busy(Busy),
`ifdef CODE_DRIVER_PHASE_EN
        .Phase(Phase),
`endif
        .Done(Done)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (Reset) begin
            o0  <= 0;
            o1  <= 0;
            cph <= 2'd0;
        end else if (En) begin
            if (!Slt) begin
                o0 <= o0 + 1;
            end else begin
                cph <= cph + 2'd1;
                if (cph == 2'd3) o1 <= o1 + 1;
            end
        end
    end

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        ReqValid = 1'b0;
        Stall = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    // Issues one request and watches until Done (bounded); records emitted cycles and En pattern
    task automatic run_req(input logic [15:0] c0, input logic [15:0] c1, input logic m,
                           input int st_at, input int st_len,
                           output int n0, output int n1, output int lat, output logic [31:0] mask);
        n0 = 0; n1 = 0; lat = -1; mask = 32'd0;
        @(negedge Clk);
        ReqValid = 1'b1; ReqCnt0 = c0; ReqCnt1 = c1; ReqMode = m;
        @(posedge Clk);
        #1 ReqValid = 1'b0;
        for (int k = 0; k < 200; k++) begin
            Stall = (k >= st_at && k < st_at + st_len);
            @(negedge Clk);
            if (En && !Slt) n0++;
            if (En && Slt) n1++;
            if (En && k < 32) mask[k] = 1'b1;
            if (Done) begin
                lat = k + 1;
                break;
            end
            @(posedge Clk);
            #1;
        end
        Stall = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        checks++;
        if ({ReqReady, En, Slt, Busy, Done} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_outputs: got rdy/en/slt/busy/done=%b, want 10000", {ReqReady, En, Slt, Busy, Done});
        end
`ifdef CODE_DRIVER_PHASE_EN
        checks++;
        if (Phase !== 2'd0) begin
            errors++;
            $display("FAIL reset_phase: got %0d, want 0", Phase);
        end
`endif
        Reset = 1'b0;
    endtask

    task automatic test_output0();
        int n0, n1, lat;
        logic [31:0] mask;
        do_reset();
        run_req(16'd3, 16'd0, 1'b0, 100, 0, n0, n1, lat, mask);
        checks++;
        if (n0 !== 3 || n1 !== 0 || lat !== 4 || mask !== 32'h7) begin
            errors++;
            $display("FAIL out0_stream: got n0=%0d n1=%0d lat=%0d mask=%h, want 3 0 4 00000007", n0, n1, lat, mask);
        end
        @(negedge Clk);
        checks++;
        if (ReqReady !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL out0_ready_after_done: got rdy=%b busy=%b done=%b, want 1 0 0", ReqReady, Busy, Done);
        end
        checks++;
        if (o0 !== 3 || o1 !== 0) begin
            errors++;
            $display("FAIL out0_counter: got Output0=%0d Output1=%0d, want 3 0", o0, o1);
        end
    endtask

    task automatic test_mode0_output1();
        int n0, n1, lat;
        logic [31:0] mask;
        do_reset();
        run_req(16'd0, 16'd2, 1'b0, 100, 0, n0, n1, lat, mask);
        @(negedge Clk);
        checks++;
        if (n0 !== 0 || n1 !== 8 || lat !== 9 || mask !== 32'hFF || o1 !== 2) begin
            errors++;
            $display("FAIL mode0_out1: got n0=%0d n1=%0d lat=%0d mask=%h Output1=%0d, want 0 8 9 000000ff 2", n0, n1, lat, mask, o1);
        end
`ifdef CODE_DRIVER_PHASE_EN
        checks++;
        if (Phase !== 2'd0) begin
            errors++;
            $display("FAIL mode0_phase: got %0d, want 0", Phase);
        end
`endif
    endtask

    task automatic test_mode_mix();
        int n0, n1, lat;
        logic [31:0] mask;
        do_reset();
        run_req(16'd0, 16'd2, 1'b1, 100, 0, n0, n1, lat, mask);
        checks++;
        if (n1 !== 2 || lat !== 3 || o1 !== 0) begin
            errors++;
            $display("FAIL mix_raw: got n1=%0d lat=%0d Output1=%0d, want 2 3 0", n1, lat, o1);
        end
        @(negedge Clk);
        run_req(16'd0, 16'd1, 1'b0, 100, 0, n0, n1, lat, mask);
        @(negedge Clk);
        checks++;
        if (n1 !== 2 || lat !== 3 || o1 !== 1) begin
            errors++;
            $display("FAIL mix_compensated: got n1=%0d lat=%0d Output1=%0d, want 2 3 1", n1, lat, o1);
        end
`ifdef CODE_DRIVER_PHASE_EN
        checks++;
        if (Phase !== 2'd0) begin
            errors++;
            $display("FAIL mix_phase: got %0d, want 0", Phase);
        end
`endif
    endtask

    task automatic test_mode1_five();
        int n0, n1, lat;
        logic [31:0] mask;
        do_reset();
        run_req(16'd0, 16'd5, 1'b1, 100, 0, n0, n1, lat, mask);
        @(negedge Clk);
        checks++;
        if (n1 !== 5 || lat !== 6 || o1 !== 1) begin
            errors++;
            $display("FAIL mode1_five: got n1=%0d lat=%0d Output1=%0d, want 5 6 1", n1, lat, o1);
        end
`ifdef CODE_DRIVER_PHASE_EN
        checks++;
        if (Phase !== 2'd1) begin
            errors++;
            $display("FAIL mode1_phase: got %0d, want 1", Phase);
        end
`endif
    endtask

    task automatic test_stall();
        int n0, n1, lat;
        logic [31:0] mask;
        do_reset();
        run_req(16'd4, 16'd0, 1'b0, 1, 2, n0, n1, lat, mask);
        checks++;
        if (n0 !== 4 || lat !== 7 || mask !== 32'h39) begin
            errors++;
            $display("FAIL stall_mid_run: got n0=%0d lat=%0d mask=%h, want 4 7 00000039", n0, lat, mask);
        end
    endtask

    task automatic test_mixed_counts();
        int n0, n1, lat;
        logic [31:0] mask;
        do_reset();
        run_req(16'd2, 16'd3, 1'b1, 100, 0, n0, n1, lat, mask);
        checks++;
        if (n0 !== 2 || n1 !== 3 || lat !== 6 || mask !== 32'h1F) begin
            errors++;
            $display("FAIL mixed_counts: got n0=%0d n1=%0d lat=%0d mask=%h, want 2 3 6 0000001f", n0, n1, lat, mask);
        end
    endtask

    task automatic test_reset_mid();
        int n0, n1, lat;
        do_reset();
        @(negedge Clk);
        ReqValid = 1'b1; ReqCnt0 = 16'd0; ReqCnt1 = 16'd2; ReqMode = 1'b0;
        @(posedge Clk);
        #1 ReqValid = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (En !== 1'b1 || Slt !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_running: got en=%b slt=%b, want 1 1", En, Slt);
        end
        Reset = 1'b1;
        ReqValid = 1'b1; ReqCnt0 = 16'd5; ReqCnt1 = 16'd0;
        #1;
        checks++;
        if ({ReqReady, En, Busy, Done} !== 4'b1000) begin
            errors++;
            $display("FAIL rstmid_same_cycle: got rdy/en/busy/done=%b, want 1000", {ReqReady, En, Busy, Done});
        end
        @(negedge Clk);
        Reset = 1'b0;
        ReqValid = 1'b0;
        @(negedge Clk);
        checks++;
        if (ReqReady !== 1'b1 || Busy !== 1'b0 || En !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_req_dropped: got rdy=%b busy=%b en=%b, want 1 0 0", ReqReady, Busy, En);
        end
`ifdef CODE_DRIVER_PHASE_EN
        checks++;
        if (Phase !== 2'd0) begin
            errors++;
            $display("FAIL rstmid_phase: got %0d, want 0", Phase);
        end
`endif
        begin
            logic [31:0] mask;
            run_req(16'd2, 16'd1, 1'b0, 100, 0, n0, n1, lat, mask);
        end
        @(negedge Clk);
        checks++;
        if (n0 !== 2 || n1 !== 4 || lat !== 7 || o0 !== 2 || o1 !== 1) begin
            errors++;
            $display("FAIL rstmid_after: got n0=%0d n1=%0d lat=%0d O0=%0d O1=%0d, want 2 4 7 2 1", n0, n1, lat, o0, o1);
        end
    endtask

    task automatic test_zero();
        int n0, n1, lat;
        logic [31:0] mask;
        do_reset();
        run_req(16'd0, 16'd0, 1'b0, 100, 0, n0, n1, lat, mask);
        checks++;
        if (n0 !== 0 || n1 !== 0 || lat !== 1) begin
            errors++;
            $display("FAIL zero_mode0: got n0=%0d n1=%0d lat=%0d, want 0 0 1", n0, n1, lat);
        end
        @(negedge Clk);
        run_req(16'd0, 16'd0, 1'b1, 100, 0, n0, n1, lat, mask);
        checks++;
        if (n0 !== 0 || n1 !== 0 || lat !== 1) begin
            errors++;
            $display("FAIL zero_mode1: got n0=%0d n1=%0d lat=%0d, want 0 0 1", n0, n1, lat);
        end
    endtask

    initial begin
        test_reset();
        test_output0();
        test_mode0_output1();
        test_mode_mix();
        test_mode1_five();
        test_stall();
        test_mixed_counts();
        test_reset_mid();
        test_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
